// File: rtl/ones_comp_checksum_acc.sv
// Streaming ones'-complement (mod 2^width-1) checksum accumulator.
// Accumulates framed words over valid/ready and emits one sum/checksum result per packet.

package lau_pkg;
    typedef enum logic {SLOW, FAST} speed_e;
endpackage

module ones_comp_checksum_acc #(
    parameter int unsigned     width    = 16,
    parameter lau_pkg::speed_e speed    = lau_pkg::FAST,
    parameter int unsigned     cntWidth = 16,
    parameter bit              normZero = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clr_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [width-1:0]    in_data_i,
    input  logic                in_last_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [width-1:0]    out_sum_o,
    output logic [width-1:0]    out_chk_o,
    output logic [cntWidth-1:0] out_cnt_o,
    output logic                out_ovf_o,
    output logic                busy_o
);

    typedef enum logic [0:0] {StIdle, StAcc} state_e;

    localparam logic [width-1:0]    AllOnes = '1;
    localparam logic [width-1:0]    AddOne  = width'(1);
    localparam logic [cntWidth-1:0] CntMax  = '1;
    localparam logic [cntWidth-1:0] CntOne  = cntWidth'(1);

    state_e              state_q, state_d;
    logic [width-1:0]    acc_q, acc_d;
    logic [cntWidth-1:0] cnt_q, cnt_d;
    logic                ovf_q, ovf_d;

    logic                res_valid_q, res_valid_d;
    logic [width-1:0]    res_sum_q, res_sum_d;
    logic [cntWidth-1:0] res_cnt_q, res_cnt_d;
    logic                res_ovf_q, res_ovf_d;

    logic [width-1:0]    sum;
    logic [width-1:0]    sum_norm;
    logic [cntWidth-1:0] cnt_inc;
    logic                cnt_sat;
    logic                beat;

    // mod 2^width-1 adder with end-around carry; all-ones survives as negative zero
    if (speed == lau_pkg::FAST) begin : g_add_fast
        logic [width:0]   s0;
        logic [width-1:0] s1;
        assign s0  = {1'b0, acc_q} + {1'b0, in_data_i};
        assign s1  = s0[width-1:0] + AddOne;
        assign sum = s0[width] ? s1 : s0[width-1:0];
    end else begin : g_add_slow
        logic [width:0] s0;
        assign s0  = {1'b0, acc_q} + {1'b0, in_data_i};
        assign sum = s0[width-1:0] + width'(s0[width]);
    end

    assign sum_norm = (normZero && (sum == AllOnes)) ? '0 : sum;
    assign cnt_sat  = (cnt_q == CntMax);
    assign cnt_inc  = cnt_sat ? cnt_q : cnt_q + CntOne;

    assign in_ready_o = (~res_valid_q | out_ready_i) & ~clr_i;
    assign beat       = in_valid_i & in_ready_o;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        res_valid_d = res_valid_q;
        res_sum_d   = res_sum_q;
        res_cnt_d   = res_cnt_q;
        res_ovf_d   = res_ovf_q;

        if (res_valid_q && out_ready_i) begin
            res_valid_d = 1'b0;
        end

        if (clr_i) begin
            state_d = StIdle;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else if (beat) begin
            // idle keeps acc/cnt/ovf at zero, so both states share one datapath
            if (in_last_i) begin
                res_valid_d = 1'b1;
                res_sum_d   = sum_norm;
                res_cnt_d   = cnt_inc;
                res_ovf_d   = ovf_q | cnt_sat;
                state_d     = StIdle;
                acc_d       = '0;
                cnt_d       = '0;
                ovf_d       = 1'b0;
            end else begin
                state_d = StAcc;
                acc_d   = sum;
                cnt_d   = cnt_inc;
                ovf_d   = ovf_q | cnt_sat;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_cnt_q   <= '0;
            res_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            res_valid_q <= res_valid_d;
            res_sum_q   <= res_sum_d;
            res_cnt_q   <= res_cnt_d;
            res_ovf_q   <= res_ovf_d;
        end
    end

    assign out_valid_o = res_valid_q;
    assign out_sum_o   = res_sum_q;
    assign out_chk_o   = ~res_sum_q;
    assign out_cnt_o   = res_cnt_q;
    assign out_ovf_o   = res_ovf_q;
    assign busy_o      = (state_q == StAcc);

endmodule

// File: doc/ones_comp_checksum_acc.md
Name: ones_comp_checksum_acc

Overview:
- Streaming ones'-complement (mod 2^n-1) checksum accumulator.
- Sits directly around an AddMod2Nm1 instance. The block feeds the adder with the running accumulator plus each incoming word, and registers the adder's sum.
- Consumes framed word streams over a valid/ready handshake. Emits one sum/checksum result per packet on an output valid/ready port.

Parameters:
width, 16, data word width (>=2)
speed, lau_pkg::FAST, passed to the internal AddMod2Nm1
cntWidth, 16, width of the per-packet word counter
normZero, 1'b0, if 1 map an all-ones result sum (negative zero) to all-zeros at output

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
clr_i  in  1  synchronous abort of the packet in progress
in_valid_i  in  1  input word valid
in_ready_o  out  1  input word accepted when in_valid_i & in_ready_o
in_data_i  in  width  input word
in_last_i  in  1  marks final word of packet
out_valid_o  out  1  result valid
out_ready_i  in  1  result consumed when out_valid_o & out_ready_i
out_sum_o  out  width  ones'-complement sum of packet (after optional normalisation)
out_chk_o  out  width  bitwise inverse of out_sum_o
out_cnt_o  out  cntWidth  words in packet, saturating at 2^cntWidth-1
out_ovf_o  out  1  word count saturated during packet
busy_o  out  1  packet in progress (state ACC)

Behaviour:
- Reset (async, rst_ni=0):
  - State IDLE; accumulator 0; word counter 0; overflow flag 0.
  - out_valid_o=0; out_sum_o=0; out_chk_o=all-ones; out_cnt_o=0; out_ovf_o=0; busy_o=0.
  - Reset mid-packet or with a pending result discards both, with no output.
- Adder: S = acc + in_data_i mod (2^width-1), double-zero representation with end-around carry.
  - 0+0=0.
  - x+~x = all-ones.
  - all-ones+all-ones = all-ones.
  - Purely combinational; the accumulator register captures S.
- in_ready_o = (~out_valid_o | out_ready_i) & ~clr_i. Combinational, no bubble when the result is drained in the same cycle.
- Beat = in_valid_i & in_ready_o.
- FSM states:
  - IDLE: acc=0, cnt=0.
    - Beat without last -> ACC; acc<=S; cnt<=1.
    - Beat with last -> load the result register from S directly, cnt=1; stay IDLE.
  - ACC: busy_o=1.
    - Beat without last -> acc<=S; cnt<=sat(cnt+1); ovf|=saturating.
    - Beat with last -> result register <= {S, sat(cnt+1), ovf}; acc<=0; cnt<=0; ovf<=0; -> IDLE.
- Result register:
  - out_valid_o set on the cycle after the last beat; held stable until the handshake.
  - Simultaneous drain and new last beat: the new result is loaded and out_valid_o stays 1.
  - Drain without a new last beat: out_valid_o<=0 and data is held.
- Normalisation (normZero=1): if S is all-ones at load, store 0. out_chk_o is always ~out_sum_o.
- Latency: one cycle from the last beat to out_valid_o. Sustained throughput is one word/cycle when out_ready_i=1.
- clr_i=1:
  - Forces in_ready_o=0, so no beat is accepted that cycle.
  - Next state IDLE; acc, cnt and ovf cleared.
  - A pending result is unaffected and still handshakes normally.
- Count saturation: cnt sticks at 2^cntWidth-1 and out_ovf_o=1 for that packet. The sum is unaffected.
- Output backpressure: with out_valid_o=1 and out_ready_i=0, in_ready_o=0. No words are lost, and the accumulator is frozen mid-packet.

Test Plan:
- RFC1071 IPv4 header, width=16: words 4500,0073,0000,4000,4011,0000,C0A8,0001,C0A8,00C7, last on final word, out_ready_i=1.
  - Required: out_sum_o=479E, out_chk_o=B861, out_cnt_o=10, out_valid_o 1 cycle after the last beat.
- End-around carry and double zero, normZero=0:
  - Packet FFFF,0001 -> sum 0001.
  - Packet 0001,FFFE -> sum FFFF, chk 0000.
  - Repeat the second packet with normZero=1 -> sum 0000, chk FFFF.
- Single-word packet 1234 with last from IDLE -> sum 1234, chk EDCB, cnt 1.
  - Back-to-back single-word packets each cycle with out_ready_i=1 -> one result per cycle, in_ready_o stays 1.
- Backpressure:
  - Hold out_ready_i=0 after the first result; in_ready_o must be 0 and the second packet's words must not be lost.
  - Release out_ready_i -> the first result drains, then the second completes with the correct sum.
- Aborts:
  - clr_i asserted after 3 words of a packet, then a new packet 0005,0007 -> sum 000C, cnt 2.
  - rst_ni pulsed low mid-packet -> all outputs return to their reset values asynchronously.
- Count saturation, cntWidth=2: 5-word packet of 0001 -> sum 0005, out_cnt_o=3, out_ovf_o=1.
  - The next packet reports out_ovf_o=0.
